// File: rtl/mux2t1_64.sv
// 2-to-1 word multiplexer with a combinational output and a one-cycle
// registered copy of the selected word and select bit.
module mux2t1_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             sel_q
);

  logic [WIDTH-1:0] o_d;

  // Plain ?: keeps standard X semantics when sel is unknown.
  assign o_d = sel ? b : a;
  assign o   = o_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_mux2t1_64.sv
// Directed self-checking bench for mux2t1_64: reset behaviour, select paths,
// full-width patterns, async reset mid-operation and equal-input cases.
module tb_mux2t1_64;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        sel;
  logic [63:0] o;
  logic [63:0] o_q;
  logic        sel_q;

  int total = 0;
  int bad   = 0;

  mux2t1_64 #(.WIDTH(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .o    (o),
    .o_q  (o_q),
    .sel_q(sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one vector between edges, check o right away, then o_q/sel_q after the edge.
  task automatic applyStimulus(input string tag, input logic [63:0] va, input logic [63:0] vb,
                               input logic vs);
    logic [63:0] expO;
    expO = vs ? vb : va;
    a   = va;
    b   = vb;
    sel = vs;
    #1;
    checkOutput({tag, ".o"}, o, expO);
    @(posedge clk);
    #1;
    checkOutput({tag, ".o_q"}, o_q, expO);
    checkOutput({tag, ".sel_q"}, {63'd0, sel_q}, {63'd0, vs});
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sel = 1'b0;
    #2;
    checkOutput("rst.o", o, 64'h0);
    checkOutput("rst.o_q", o_q, 64'h0);
    checkOutput("rst.sel_q", {63'd0, sel_q}, 64'h0);

    // Inputs move during reset: o follows, registers stay cleared across edges.
    a   = 64'hFFFF_FFFF_FFFF_FFFF;
    b   = 64'h5555_AAAA_5555_AAAA;
    sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hold.o", o, 64'h5555_AAAA_5555_AAAA);
    checkOutput("rst_hold.o_q", o_q, 64'h0);
    checkOutput("rst_hold.sel_q", {63'd0, sel_q}, 64'h0);

    a   = '0;
    b   = '0;
    sel = 1'b0;
    #(100 - $time);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("sel_a", 64'h1, 64'h0, 1'b0);
    applyStimulus("sel_b", 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    applyStimulus("zeros", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2) ? "width_b" : "width_a",
                    64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, i[0]);
      checkOutput("width.bit63", {63'd0, o_q[63]}, {63'd0, ~i[0]});
      checkOutput("width.bit0", {63'd0, o_q[0]}, {63'd0, ~i[0]});
    end

    // Load a known word, then reset between edges.
    applyStimulus("preload", 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async.o_q", o_q, 64'h0);
    checkOutput("async.sel_q", {63'd0, sel_q}, 64'h0);
    checkOutput("async.o", o, 64'hDEAD_BEEF_0123_4567);
    sel = 1'b0;
    #1;
    checkOutput("async.o_track", o, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("async.hold", o_q, 64'h0);

    a   = 64'h0123_4567_89AB_CDEF;
    b   = 64'h0123_4567_89AB_CDEF;
    sel = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("equal", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, ~i[0]);
    end

    // Bits where a and b differ per position check per-bit independence.
    applyStimulus("mixed_a", 64'hF0F0_0000_FFFF_1234, 64'h0F0F_FFFF_0000_EDCB, 1'b0);
    applyStimulus("mixed_b", 64'hF0F0_0000_FFFF_1234, 64'h0F0F_FFFF_0000_EDCB, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2t1_64.md
Name: mux2t1_64

Overview:
- 64-bit 2-to-1 word multiplexer for datapath operand and result selection.
- Primary output o is purely combinational: a when sel=0, b when sel=1.
- A registered copy of the selected word and select bit is also provided. Downstream stages that need a timing break use these instead of o.
- One clock, clk. Reset rst is asynchronous and active-high.

Parameters:
- WIDTH, 64, data width of a, b, o and o_q.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registers immediately.
- a  input  WIDTH  data input 0, selected when sel=0.
- b  input  WIDTH  data input 1, selected when sel=1.
- sel  input  1  select: 0 -> a, 1 -> b.
- o  output  WIDTH  combinational mux output.
- o_q  output  WIDTH  registered mux output.
- sel_q  output  1  registered copy of sel, aligned with o_q.

Behaviour:
- Combinational output o:
  - o = sel ? b : a, bitwise across all WIDTH bits.
  - Zero latency; no dependence on clk or rst.
  - o is valid during reset.
  - Any change on a, b or sel propagates to o in the same delta/settle time.
- Registered outputs on each rising clk edge with rst=0:
  - o_q <= (sel ? b : a)
  - sel_q <= sel
  - Latency is exactly 1 cycle: o_q equals the value o had just before that edge.
- Reset:
  - While rst=1, o_q=0 and sel_q=0, asserted asynchronously without waiting for a clk edge.
  - On rst deassertion, the first rising edge with rst=0 loads normally.
  - rst asserted mid-operation clears o_q and sel_q immediately; o is unaffected.
- Width rules:
  - Full WIDTH bits pass unchanged: no sign or zero extension, no truncation.
  - Bit i of o depends only on bit i of a and b, plus sel.
- Boundary conditions:
  - a == b: o = a regardless of sel.
  - sel toggling every cycle: o_q alternates between the sampled a and b values with no bubble.
  - All-ones and all-zeros words pass intact; bit 63 and bit 0 must be checked.
- X handling:
  - sel=X gives o=X on bits where a and b differ, and the common value where they are equal (standard ?: semantics). This is acceptable; no X-filtering logic.
- No handshake and no internal state beyond the two registers.

Test Plan:
- Reset/init: rst=1 with a=0, b=0, sel=0 -> o=0, o_q=0, sel_q=0; o_q stays 0 while rst=1 despite clk edges.
- Basic select a: after 100 ns set a=1, b=0, sel=0 -> o=64'h1 immediately; after next rising edge o_q=64'h1, sel_q=0.
- Basic select b: a=64'h1, b=64'hFFFF_FFFF_FFFF_FFFF, sel=1 -> o=64'hFFFF_FFFF_FFFF_FFFF; next edge o_q=64'hFFFF_FFFF_FFFF_FFFF, sel_q=1.
- Full-width integrity: a=64'h8000_0000_0000_0001, b=64'h7FFF_FFFF_FFFF_FFFE, toggle sel each cycle -> o and o_q alternate between the exact patterns with bit 63 and bit 0 correct.
- Async reset mid-operation: with o_q=64'hDEAD_BEEF_0123_4567, assert rst between clock edges -> o_q=0 and sel_q=0 before the next edge; o still tracks sel ? b : a.
- Equal inputs: a=b=64'h0123_4567_89AB_CDEF, sel toggling -> o constant at 64'h0123_4567_89AB_CDEF, and o_q the same from the first edge after reset release.
